// File: rtl/rom_port_arbiter_if.sv
// Request/response bundle between four ROM clients and the shared-ROM arbiter.
// The master side drives requests and response acceptance; the slave side is the arbiter.
interface rom_port_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
);
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [15:0]       rsp_data;
    logic [1:0]        rsp_id;
    logic              rsp_ready;
    logic              busy;
    logic [CNT_W-1:0]  txn_count;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy, txn_count
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy, txn_count
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one single-ported 16x16 one-hot ROM among four requesters.
// One transaction in flight: IDLE grants, LOOKUP reads the ROM, RESP holds the tagged word.
module rom_port_arbiter #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    rom_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [3:0]       r_addr;
    logic [1:0]       r_id;
    logic             r_rsp_valid;
    logic [15:0]      r_rsp_data;
    logic [1:0]       r_rsp_id;
    logic [CNT_W-1:0] r_txn_count;

    logic             w_any;
    logic [1:0]       w_winner;
    logic [1:0]       w_cand;
    logic [15:0]      w_rom_data;

    function automatic logic [15:0] rom_lookup(input logic [3:0] addr);
        return 16'h0001 << addr;
    endfunction

    // Search ptr, ptr+1, ... wrapping; the first valid requester wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        w_any    = 1'b0;
        w_winner = r_ptr;
        w_cand   = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_any && bus.req_valid[w_cand]) begin
                w_any    = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_rom_data    = rom_lookup(r_addr);

    assign bus.req_ready = (!rst && r_state == IDLE && w_any) ? (4'b0001 << w_winner) : 4'b0000;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.busy      = (r_state != IDLE);
    assign bus.txn_count = r_txn_count;

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= 2'd0;
            r_addr      <= 4'd0;
            r_id        <= 2'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 16'h0000;
            r_rsp_id    <= 2'd0;
            r_txn_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_addr  <= bus.req_addr[{w_winner, 2'b00} +: 4];
                        r_id    <= w_winner;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    r_rsp_data  <= w_rom_data;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    // The requester just served drops to lowest priority.
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_txn_count <= r_txn_count + 1'b1;
                        r_ptr       <= r_id + 2'd1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter; inputs change and outputs are sampled 1-2 time units after the rising edge.
module tb_rom_port_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rom_port_arbiter_if #(.NREQ(4), .CNT_W(8)) bus ();

    rom_port_arbiter #(.NREQ(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_addr(input int r, input logic [3:0] a);
        bus.req_addr[r*4 +: 4] = a;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [15:0] fair_data [4] = '{16'h0001, 16'h0080, 16'h1000, 16'h8000};
    logic [1:0]  fair_id   [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_addr  = 16'h0000;
        bus.rsp_ready = 1'b1;

        // Reset state, with requests present that must be ignored.
        tick();
        bus.req_valid = 4'b1111;
        tick();
        settle();
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
        check("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
        check("rst_busy",      32'(bus.busy),      32'h0);
        check("rst_txn",       32'(bus.txn_count), 32'h0);

        // Single request from requester 2, address 5.
        do_reset();
        bus.req_valid = 4'b0100;
        set_addr(2, 4'd5);
        settle();
        check("single_ready_T", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 4'b0000;
        settle();
        check("single_lookup_valid", 32'(bus.rsp_valid), 32'h0);
        check("single_lookup_busy",  32'(bus.busy),      32'h1);
        tick();
        check("single_T2_valid", 32'(bus.rsp_valid), 32'h1);
        check("single_T2_data",  32'(bus.rsp_data),  32'h0020);
        check("single_T2_id",    32'(bus.rsp_id),    32'h2);
        tick();
        check("single_done_valid", 32'(bus.rsp_valid), 32'h0);
        check("single_done_txn",   32'(bus.txn_count), 32'h1);
        check("single_done_busy",  32'(bus.busy),      32'h0);

        // Fairness: all four held valid, one response every 3 cycles.
        do_reset();
        set_addr(0, 4'd0);
        set_addr(1, 4'd7);
        set_addr(2, 4'd12);
        set_addr(3, 4'd15);
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            settle();
            check($sformatf("fair%0d_ready", n), 32'(bus.req_ready), 32'(4'b0001 << fair_id[n]));
            tick();
            check($sformatf("fair%0d_lookup", n), 32'(bus.rsp_valid), 32'h0);
            tick();
            check($sformatf("fair%0d_valid", n), 32'(bus.rsp_valid), 32'h1);
            check($sformatf("fair%0d_id", n),    32'(bus.rsp_id),    32'(fair_id[n]));
            check($sformatf("fair%0d_data", n),  32'(bus.rsp_data),  32'(fair_data[fair_id[n]]));
            tick();
        end
        bus.req_valid = 4'b0000;
        check("fair_txn", 32'(bus.txn_count), 32'd6);

        // Backpressure: five stalled cycles in RESP with requesters 0 and 1 pending.
        do_reset();
        set_addr(0, 4'd3);
        set_addr(1, 4'd9);
        bus.req_valid = 4'b0011;
        bus.rsp_ready = 1'b0;
        settle();
        check("bp_ready_first", 32'(bus.req_ready), 32'h1);
        tick();
        tick();
        check("bp_resp_data", 32'(bus.rsp_data), 32'h0008);
        for (int n = 0; n < 5; n++) begin
            tick();
            check($sformatf("bp%0d_valid", n), 32'(bus.rsp_valid), 32'h1);
            check($sformatf("bp%0d_data", n),  32'(bus.rsp_data),  32'h0008);
            check($sformatf("bp%0d_id", n),    32'(bus.rsp_id),    32'h0);
            check($sformatf("bp%0d_ready", n), 32'(bus.req_ready), 32'h0);
            check($sformatf("bp%0d_busy", n),  32'(bus.busy),      32'h1);
        end
        bus.rsp_ready = 1'b1;
        tick();
        settle();
        check("bp_release_txn",   32'(bus.txn_count), 32'h1);
        check("bp_release_valid", 32'(bus.rsp_valid), 32'h0);
        check("bp_next_grant",    32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        check("bp_next_data", 32'(bus.rsp_data), 32'h0200);
        check("bp_next_id",   32'(bus.rsp_id),   32'h1);
        tick();

        // Reset while in LOOKUP, after a completed transaction moved ptr to 3.
        do_reset();
        set_addr(2, 4'd1);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
        check("mid_pre_txn", 32'(bus.txn_count), 32'h1);
        set_addr(0, 4'd4);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = 4'b0000;
        check("mid_in_lookup", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
        check("mid_rst_busy",  32'(bus.busy),      32'h0);
        rst = 1'b0;
        tick();
        check("mid_after_valid", 32'(bus.rsp_valid), 32'h0);
        check("mid_after_txn",   32'(bus.txn_count), 32'h0);
        set_addr(1, 4'd2);
        set_addr(3, 4'd11);
        bus.req_valid = 4'b1010;
        settle();
        check("mid_ptr_restart", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 4'b1000;
        tick();
        check("mid_r1_data", 32'(bus.rsp_data), 32'h0004);
        tick();
        settle();
        check("mid_r3_grant", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        check("mid_r3_data", 32'(bus.rsp_data), 32'h0800);
        check("mid_r3_id",   32'(bus.rsp_id),   32'h3);
        tick();

        // Counter wrap over 256 transactions from requester 0.
        do_reset();
        bus.req_valid = 4'b0001;
        for (int n = 0; n < 256; n++) begin
            set_addr(0, 4'(n));
            tick();
            tick();
            check($sformatf("wrap%0d_data", n), 32'(bus.rsp_data), 32'(16'h0001 << (n % 16)));
            tick();
            if (n == 254) check("wrap_255", 32'(bus.txn_count), 32'd255);
            if (n == 255) check("wrap_0",   32'(bus.txn_count), 32'd0);
        end
        bus.req_valid = 4'b0000;
        tick();
        tick();
        tick();

        // Hold-off: requester 1 rises during RESP and waits for IDLE.
        do_reset();
        set_addr(0, 4'd2);
        set_addr(1, 4'd6);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        bus.req_valid = 4'b0010;
        settle();
        check("hold_resp_ready0", 32'(bus.req_ready), 32'h0);
        tick();
        check("hold_stall_ready", 32'(bus.req_ready), 32'h0);
        bus.rsp_ready = 1'b1;
        settle();
        check("hold_hs_ready", 32'(bus.req_ready), 32'h0);
        tick();
        check("hold_idle_grant", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        check("hold_data", 32'(bus.rsp_data), 32'h0040);
        check("hold_id",   32'(bus.rsp_id),   32'h1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
